// File: rtl/program_loader.sv
// program_loader: receives a length-prefixed, XOR-checksummed byte stream,
// assembles 12-bit instruction words, writes them to instruction memory
// from address 0 upward and pulses start after a clean load.
module program_loader #(
  parameter int reg_width = 12,
  parameter int Im_width  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_req,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic                 rx_ready,
  output logic [Im_width-1:0]  im_address,
  output logic [reg_width-1:0] im_data,
  output logic                 im_wren,
  output logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_CNT_LO = 4'd1;
  localparam logic [3:0] S_CNT_HI = 4'd2;
  localparam logic [3:0] S_W_LO   = 4'd3;
  localparam logic [3:0] S_W_HI   = 4'd4;
  localparam logic [3:0] S_WRITE  = 4'd5;
  localparam logic [3:0] S_CHK    = 4'd6;
  localparam logic [3:0] S_DONE   = 4'd7;
  localparam logic [3:0] S_ERR    = 4'd8;

  // Largest legal word count: the whole instruction memory.
  localparam logic [11:0] max_count = 12'(2 ** Im_width);

  logic [3:0]           state_reg;
  logic [Im_width-1:0]  counter_reg;
  logic [11:0]          count_reg;
  logic [7:0]           xor_reg;
  logic [7:0]           lo_byte_reg;
  logic [reg_width-1:0] word_reg;
  logic                 start_reg;
  logic                 done_reg;
  logic                 error_reg;

  logic                 accept;
  logic [11:0]          new_count;
  logic                 last_word;

  // count_lo was parked in the low byte of count_reg during CNT_LO.
  assign new_count = {rx_data[3:0], count_reg[7:0]};
  // The word being written is the last one when counter+1 reaches count.
  assign last_word = ((12'(counter_reg) + 12'd1) == count_reg);
  assign accept    = rx_valid && rx_ready;

  // Outputs decode directly from registered state and datapath registers.
  assign rx_ready   = (state_reg == S_CNT_LO) || (state_reg == S_CNT_HI) ||
                      (state_reg == S_W_LO)   || (state_reg == S_W_HI)   ||
                      (state_reg == S_CHK);
  assign busy       = !((state_reg == S_IDLE) || (state_reg == S_DONE) ||
                        (state_reg == S_ERR));
  assign im_wren    = (state_reg == S_WRITE);
  assign im_address = counter_reg;
  assign im_data    = word_reg;
  assign start      = start_reg;
  assign done       = done_reg;
  assign error      = error_reg;

  // Load FSM together with counter, checksum, word assembly and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= S_IDLE;
      counter_reg <= '0;
      count_reg   <= '0;
      xor_reg     <= '0;
      lo_byte_reg <= '0;
      word_reg    <= '0;
      start_reg   <= 1'b0;
      done_reg    <= 1'b0;
      error_reg   <= 1'b0;
    end else begin
      start_reg <= 1'b0;
      case (state_reg)
        S_IDLE, S_DONE, S_ERR: begin
          if (load_req) begin
            state_reg   <= S_CNT_LO;
            counter_reg <= '0;
            xor_reg     <= '0;
            done_reg    <= 1'b0;
            error_reg   <= 1'b0;
          end
        end
        S_CNT_LO: begin
          if (accept) begin
            count_reg <= {4'd0, rx_data};
            xor_reg   <= xor_reg ^ rx_data;
            state_reg <= S_CNT_HI;
          end
        end
        S_CNT_HI: begin
          if (accept) begin
            count_reg <= new_count;
            xor_reg   <= xor_reg ^ rx_data;
            if ((rx_data[7:4] != 4'd0) || (new_count == 12'd0) ||
                (new_count > max_count)) begin
              state_reg <= S_ERR;
              error_reg <= 1'b1;
            end else begin
              state_reg <= S_W_LO;
            end
          end
        end
        S_W_LO: begin
          if (accept) begin
            lo_byte_reg <= rx_data;
            xor_reg     <= xor_reg ^ rx_data;
            state_reg   <= S_W_HI;
          end
        end
        S_W_HI: begin
          if (accept) begin
            // Upper nibble of word_hi only feeds the checksum.
            word_reg  <= reg_width'({rx_data[3:0], lo_byte_reg});
            xor_reg   <= xor_reg ^ rx_data;
            state_reg <= S_WRITE;
          end
        end
        S_WRITE: begin
          // Wraps to 0 after a full-memory load; harmless since we stop here.
          counter_reg <= counter_reg + 1'b1;
          state_reg   <= last_word ? S_CHK : S_W_LO;
        end
        S_CHK: begin
          if (accept) begin
            if (rx_data == xor_reg) begin
              state_reg <= S_DONE;
              done_reg  <= 1'b1;
              start_reg <= 1'b1;
            end else begin
              state_reg <= S_ERR;
              error_reg <= 1'b1;
            end
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: table-driven loads, randomized
// loads against a stream-level reference model, and hand-written sequences
// for load_req-while-busy, mid-load reset and reload.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_req;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  im_address;
  logic [11:0] im_data;
  logic        im_wren;
  logic        start;
  logic        busy;
  logic        done;
  logic        error;

  program_loader #(.reg_width(12), .Im_width(8)) dut (
    .clk(clk), .reset(reset), .load_req(load_req),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .im_address(im_address), .im_data(im_data), .im_wren(im_wren),
    .start(start), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Free-running edge counter used to measure start latency.
  always @(posedge clk) cyc <= cyc + 1;

  // Write and start monitor, sampled on the falling edge.
  logic [7:0]  mon_addr[$];
  logic [11:0] mon_data[$];
  int          start_cnt = 0;
  int          start_cyc = 0;
  always @(negedge clk) begin
    if (im_wren) begin
      mon_addr.push_back(im_address);
      mon_data.push_back(im_data);
    end
    if (start) begin
      start_cnt = start_cnt + 1;
      start_cyc = cyc;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Reference model: interprets the byte stream directly.
  logic [7:0]  exp_addr[$];
  logic [11:0] exp_data[$];
  bit          exp_ok;
  bit          exp_err;
  int          exp_n;

  task automatic model(input logic [7:0] b[$]);
    int cnt;
    logic [7:0] x;
    exp_addr.delete();
    exp_data.delete();
    exp_ok  = 1'b0;
    exp_err = 1'b0;
    cnt = int'(b[1][3:0]) * 256 + int'(b[0]);
    exp_n = cnt;
    if (b[1][7:4] != 4'd0 || cnt == 0 || cnt > 256) begin
      exp_err = 1'b1;
      return;
    end
    x = 8'd0;
    for (int j = 0; j < 2 + 2 * cnt; j++) x = x ^ b[j];
    for (int i = 0; i < cnt; i++) begin
      exp_addr.push_back(8'(i % 256));
      exp_data.push_back({b[3 + 2 * i][3:0], b[2 + 2 * i]});
    end
    if (b[2 + 2 * cnt] == x) exp_ok = 1'b1;
    else exp_err = 1'b1;
  endtask

  task automatic build(input logic [7:0] lo, input logic [7:0] hi, input int nw,
                       input bit corrupt, output logic [7:0] s[$]);
    logic [7:0] x;
    logic [7:0] v;
    s.delete();
    s.push_back(lo);
    s.push_back(hi);
    x = lo ^ hi;
    for (int i = 0; i < 2 * nw; i++) begin
      v = 8'($urandom);
      s.push_back(v);
      x = x ^ v;
    end
    s.push_back(corrupt ? (x ^ 8'h01) : x);
  endtask

  // Pulses load_req and offers the stream; stall 0=always valid,
  // 1=valid pattern 1,0,0,1, 2=random valid.
  task automatic drive_stream(input logic [7:0] s[$], input int stall, output int edge0);
    int i = 0;
    int k = 0;
    int guard = 0;
    bit v;
    bit acc;
    @(negedge clk);
    load_req = 1'b1;
    edge0 = cyc + 1;
    @(negedge clk);
    load_req = 1'b0;
    while (i < s.size() && busy) begin
      if (stall == 0) v = 1'b1;
      else if (stall == 1) v = ((k % 4) == 0) || ((k % 4) == 3);
      else v = ($urandom_range(0, 1) == 1);
      rx_valid = v;
      rx_data  = s[i];
      acc = v && rx_ready;
      @(negedge clk);
      if (acc) i++;
      k++;
      guard++;
      if (guard > 5000) begin
        check("stream_timeout", guard, 0);
        break;
      end
    end
    rx_valid = 1'b0;
    guard = 0;
    while (busy && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (busy) check("busy_timeout", 1, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("send_timeout", t, 0);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  // Runs one load and compares everything against the model.
  task automatic run_load(input string tag, input logic [7:0] s[$], input int stall,
                          output int nwr, output int first);
    int w0;
    int s0;
    int e0;
    int n;
    w0 = mon_addr.size();
    s0 = start_cnt;
    model(s);
    drive_stream(s, stall, e0);
    nwr = mon_addr.size() - w0;
    first = w0;
    check({tag, "_done"}, int'(done), int'(exp_ok));
    check({tag, "_error"}, int'(error), int'(exp_err));
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_rx_ready"}, int'(rx_ready), 0);
    check({tag, "_nwrites"}, nwr, exp_addr.size());
    n = (nwr < exp_addr.size()) ? nwr : exp_addr.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_addr"}, int'(mon_addr[w0 + i]), int'(exp_addr[i]));
      check({tag, "_data"}, int'(mon_data[w0 + i]), int'(exp_data[i]));
    end
    check({tag, "_starts"}, start_cnt - s0, exp_ok ? 1 : 0);
    if (exp_ok && stall == 0)
      check({tag, "_start_latency"}, start_cyc - e0, 3 * exp_n + 3);
    $display("load %s: bytes=%0d writes=%0d done=%0b error=%0b", tag, s.size(), nwr, done, error);
  endtask

  typedef struct {
    logic [7:0] lo;
    logic [7:0] hi;
    int         nw;
    bit         corrupt;
    int         stall;
    bit         e_done;
    bit         e_err;
    int         e_wr;
  } vec_t;

  vec_t        vt[9];
  logic [7:0]  s[$];
  int          nwr;
  int          first;
  int          w0;
  int          s0;

  initial begin
    vt[0] = '{8'h02, 8'h00, 2,   1'b0, 0, 1'b1, 1'b0, 2};
    vt[1] = '{8'h02, 8'h00, 2,   1'b1, 0, 1'b0, 1'b1, 2};
    vt[2] = '{8'h00, 8'h00, 0,   1'b0, 0, 1'b0, 1'b1, 0};
    vt[3] = '{8'h01, 8'h01, 0,   1'b0, 0, 1'b0, 1'b1, 0};
    vt[4] = '{8'h00, 8'h01, 256, 1'b0, 0, 1'b1, 1'b0, 256};
    vt[5] = '{8'h02, 8'h00, 2,   1'b0, 1, 1'b1, 1'b0, 2};
    vt[6] = '{8'h10, 8'h20, 0,   1'b0, 0, 1'b0, 1'b1, 0};
    vt[7] = '{8'h01, 8'h00, 1,   1'b0, 0, 1'b1, 1'b0, 1};
    vt[8] = '{8'h03, 8'h00, 3,   1'b0, 2, 1'b1, 1'b0, 3};

    reset = 1'b1;
    load_req = 1'b0;
    rx_data = 8'h00;
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rx_ready", int'(rx_ready), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_wren", int'(im_wren), 0);
    check("rst_start", int'(start), 0);
    check("rst_done", int'(done), 0);
    check("rst_error", int'(error), 0);
    check("rst_addr", int'(im_address), 0);
    check("rst_data", int'(im_data), 0);
    reset = 1'b0;
    @(negedge clk);

    // Table-driven loads.
    for (int t = 0; t < 9; t++) begin
      build(vt[t].lo, vt[t].hi, vt[t].nw, vt[t].corrupt, s);
      run_load($sformatf("vec%0d", t), s, vt[t].stall, nwr, first);
      check($sformatf("vec%0d_tbl_done", t), int'(done), int'(vt[t].e_done));
      check($sformatf("vec%0d_tbl_error", t), int'(error), int'(vt[t].e_err));
      check($sformatf("vec%0d_tbl_writes", t), nwr, vt[t].e_wr);
    end

    // Randomized loads against the model.
    for (int r = 0; r < 15; r++) begin
      build(8'($urandom_range(1, 6)), 8'h00, 0, 1'b0, s);
      build(s[0], 8'h00, int'(s[0]), ($urandom_range(0, 3) == 0), s);
      run_load($sformatf("rnd%0d", r), s, $urandom_range(0, 2), nwr, first);
    end

    // load_req pulsed while in W_HI must be ignored.
    w0 = mon_addr.size();
    s0 = start_cnt;
    @(negedge clk); load_req = 1'b1;
    @(negedge clk); load_req = 1'b0;
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h5A);
    @(negedge clk); load_req = 1'b1;
    @(negedge clk); load_req = 1'b0;
    check("whi_req_busy", int'(busy), 1);
    send_byte(8'hF3);
    send_byte(8'hA8);
    repeat (3) @(negedge clk);
    check("whi_req_done", int'(done), 1);
    check("whi_req_writes", mon_addr.size() - w0, 1);
    if (mon_addr.size() > w0) begin
      check("whi_req_addr", int'(mon_addr[w0]), 0);
      check("whi_req_data", int'(mon_data[w0]), 12'h35A);
    end
    check("whi_req_starts", start_cnt - s0, 1);
    $display("load whi_req: writes=%0d done=%0b error=%0b", mon_addr.size() - w0, done, error);

    // Reset asserted in W_LO of word 1.
    w0 = mon_addr.size();
    s0 = start_cnt;
    @(negedge clk); load_req = 1'b1;
    @(negedge clk); load_req = 1'b0;
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h23);
    send_byte(8'h01);
    @(negedge clk);
    @(negedge clk);
    check("mid_rst_in_wlo", int'(rx_ready), 1);
    reset = 1'b1;
    rx_valid = 1'b1;
    rx_data = 8'hBC;
    @(posedge clk);
    #1;
    check("mid_rst_rx_ready", int'(rx_ready), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_wren", int'(im_wren), 0);
    check("mid_rst_start", int'(start), 0);
    check("mid_rst_done", int'(done), 0);
    check("mid_rst_error", int'(error), 0);
    check("mid_rst_addr", int'(im_address), 0);
    check("mid_rst_data", int'(im_data), 0);
    reset = 1'b0;
    rx_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("mid_rst_writes", mon_addr.size() - w0, 1);
    check("mid_rst_starts", start_cnt - s0, 0);
    $display("load mid_reset: writes=%0d busy=%0b", mon_addr.size() - w0, busy);

    // Reload with the reference stream; must restart at address 0.
    s = '{8'h02, 8'h00, 8'h23, 8'h01, 8'hBC, 8'h0A, 8'h96};
    run_load("reload", s, 0, nwr, first);
    check("reload_nwrites", nwr, 2);
    if (nwr == 2) begin
      check("reload_addr0", int'(mon_addr[first]), 0);
      check("reload_data0", int'(mon_data[first]), 12'h123);
      check("reload_addr1", int'(mon_addr[first + 1]), 1);
      check("reload_data1", int'(mon_data[first + 1]), 12'hABC);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Upstream feeder for the instruction memory of the 12-bit processor. Receives a length-prefixed, checksummed byte stream over a valid/ready handshake and assembles 12-bit instruction words. Writes them to consecutive instruction-memory addresses starting at 0, then pulses the processor's `start` input. Drives the instruction-memory `data`/`wren` ports; the address mux toward the memory (loader vs. AR) is owned by the top level and switched on `busy`.

## Interface

Parameters:
- `reg_width`, 12, instruction word width.
- `Im_width`, 8, instruction-memory address width; max program length is 2^Im_width words.

Ports:
- `clk` in 1: single system clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `load_req` in 1: request a new load; sampled only in IDLE, DONE or ERR.
- `rx_data` in 8: stream byte.
- `rx_valid` in 1: `rx_data` valid.
- `rx_ready` out 1: loader can accept a byte. A byte transfers on a rising edge where `rx_valid && rx_ready`.
- `im_address` out Im_width: instruction-memory write address.
- `im_data` out reg_width: instruction-memory write data.
- `im_wren` out 1: instruction-memory write enable.
- `start` out 1: one-cycle pulse to the processor after a successful load.
- `busy` out 1: load in progress.
- `done` out 1: last load succeeded; held until the next load or reset.
- `error` out 1: last load failed; held until the next load or reset.

## Operation

- Stream format:
  - count_lo, count_hi: count = {count_hi[3:0], count_lo}.
  - Then count × (word_lo, word_hi): word = {word_hi[3:0], word_lo}.
  - Then chk. chk must equal the XOR of every preceding byte of the load, including both count bytes.
  - `word_hi[7:4]` is ignored for the word value but is included in the XOR.
- FSM states and transitions:
  - IDLE: waits for `load_req`, then goes to CNT_LO.
  - CNT_LO: accepts a byte, goes to CNT_HI.
  - CNT_HI: accepts a byte. Goes to ERR if `count_hi[7:4]` ≠ 0, count = 0, or count > 2^Im_width; otherwise goes to W_LO.
  - W_LO: accepts a byte, goes to W_HI.
  - W_HI: accepts a byte, goes to WRITE.
  - WRITE: stays exactly one cycle. Goes to CHK if this was the last word, else to W_LO.
  - CHK: accepts a byte. Goes to DONE if it matches the running XOR, else to ERR.
  - DONE and ERR: go to CNT_LO on `load_req`.
- `rx_ready` = 1 only in CNT_LO, CNT_HI, W_LO, W_HI and CHK. While `rx_valid` is 0 the FSM holds state indefinitely.
- Write counter:
  - Reset to 0 on entry to CNT_LO.
  - Incremented after each WRITE.
  - Wraps modulo 2^Im_width. With count = 2^Im_width the last write is to address 2^Im_width−1, and the wrap to 0 is harmless.
- In WRITE: `im_wren` = 1, `im_address` = counter, `im_data` = assembled word. Outside WRITE `im_wren` = 0.
- `busy` = 1 in every state except IDLE, DONE and ERR.
- On entering CNT_LO: `done` and `error` clear, and the running XOR clears.
- ERR entry sets `error`; no `start` pulse is issued. Words already written stay in memory.
- DONE entry sets `done` and pulses `start` for exactly one cycle.
- `load_req` in any busy state is ignored.
- Bytes offered while `rx_ready` = 0 are not consumed.

## Timing

- Reset values: state IDLE; `rx_ready`, `im_wren`, `start`, `busy`, `done`, `error` all 0; `im_address`, `im_data`, counter, XOR and count registers all 0.
- A reset asserted mid-load returns to IDLE on the next edge, with no further writes and no `start`.
- All outputs are driven from registers: state, counter, word and flag registers only.
- Reference latency, with `rx_valid` held high and count = N:
  - Edge 0 samples `load_req`.
  - Edges 1 and 2 take the count bytes.
  - Each word takes 3 edges (lo, hi, WRITE).
  - Edge 3N+3 takes chk.
  - `start` is high for the one cycle following edge 3N+3.
- Throughput is one word per 3 cycles maximum.
- `done`/`error` become visible in the same cycle as the DONE/ERR state.

## Test plan

- Good load, bytes 02,00,23,01,BC,0A,96 with `rx_valid` held high:
  - writes 0x123@0 then 0xABC@1;
  - `start` is a single pulse after edge 9;
  - `done` = 1, `error` = 0.
- Same stream with chk = 0x97: both words are written, `error` = 1, no `start` pulse, `done` = 0.
- Count bytes 00,00: goes to ERR right after the count; `rx_ready` = 0; no writes.
- Count bytes 01,01 (257): goes to ERR, no writes.
- Count 00,01 (256), with chk equal to the correct XOR:
  - 256 writes to addresses 0..255 in order;
  - `done` = 1 and one `start` pulse.
- Stalls and reset:
  - Good 2-word load with `rx_valid` toggling 1,0,0,1: writes match the no-stall case.
  - `load_req` pulsed while in W_HI is ignored.
  - Asserting `reset` in W_LO of word 1: IDLE next cycle, all outputs at reset values, no further `im_wren`.
  - A subsequent `load_req` reloads from address 0.
